seq_divider: RTL

Multi-cycle restoring divider with a parametrised operand width, selectable signed/unsigned mode, a start/done handshake and a divide-by-zero flag. It computes one quotient bit per clock, so it replaces the single-cycle divider in the ALU where a wide combinational divide would limit clock frequency. It sits behind the ALU operation decoder, which issues `start` and stalls on `busy`.

---
 rtl/seq_divider_if.sv | 32 +++
 rtl/seq_divider.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider.
//
// Handshake: the master raises start for one cycle (or holds it) with
// signed_mode/dividend/divisor valid in that same cycle; the slave samples
// them only while idle (busy low). busy is high while the slave is iterating
// and further start requests are ignored. done is a one-cycle pulse marking
// the cycle in which quotient/remainder/div_by_zero were updated; those
// results hold until the next completion. A start presented in the done
// cycle is accepted.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or
// unsigned operands, divide-by-zero reported in a single cycle.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,          // asynchronous, active-low
  seq_divider_if.slave bus,
  output logic         o_dbg_state   // 0 = IDLE, 1 = RUN
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [WIDTH:0]    r_rem,    w_rem_nxt;    // partial remainder, WIDTH+1 bits
  logic [WIDTH-1:0]  r_work,   w_work_nxt;   // dividend bits out, quotient bits in
  logic [WIDTH-1:0]  r_dvs,    w_dvs_nxt;    // divisor magnitude
  logic [CW-1:0]     r_cnt,    w_cnt_nxt;
  logic              r_neg_q,  w_neg_q_nxt;
  logic              r_neg_r,  w_neg_r_nxt;
  logic [WIDTH-1:0]  r_quot,   w_quot_nxt;
  logic [WIDTH-1:0]  r_remd,   w_remd_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_dbz,    w_dbz_nxt;

  // Operand magnitudes and sign bits taken at the request.
  logic              w_a_neg;
  logic              w_b_neg;
  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;

  // One restoring step. The extra top bit of w_shift/w_diff carries the
  // borrow, so the trial subtraction never overflows.
  logic [WIDTH+1:0]  w_shift;
  logic [WIDTH+1:0]  w_diff;
  logic              w_ge;
  logic [WIDTH:0]    w_step_rem;
  logic [WIDTH-1:0]  w_step_work;
  logic [WIDTH-1:0]  w_q_fin;
  logic [WIDTH-1:0]  w_r_fin;

  assign w_a_neg     = bus.signed_mode & bus.dividend[WIDTH-1];
  assign w_b_neg     = bus.signed_mode & bus.divisor[WIDTH-1];
  // Most-negative value maps to its unsigned magnitude (0x8000 -> 32768).
  assign w_a_mag     = w_a_neg ? (-bus.dividend) : bus.dividend;
  assign w_b_mag     = w_b_neg ? (-bus.divisor)  : bus.divisor;

  assign w_shift     = {r_rem, r_work[WIDTH-1]};
  assign w_diff      = w_shift - {2'b00, r_dvs};
  assign w_ge        = ~w_diff[WIDTH+1];
  assign w_step_rem  = w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  assign w_step_work = {r_work[WIDTH-2:0], w_ge};

  // Quotient negates on differing signs (overflow wraps to most-negative);
  // remainder follows the dividend sign.
  assign w_q_fin     = r_neg_q ? (-w_step_work) : w_step_work;
  assign w_r_fin     = r_neg_r ? (-w_step_rem[WIDTH-1:0]) : w_step_rem[WIDTH-1:0];

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_work_nxt  = r_work;
    w_dvs_nxt   = r_dvs;
    w_cnt_nxt   = r_cnt;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    w_quot_nxt  = r_quot;
    w_remd_nxt  = r_remd;
    w_done_nxt  = 1'b0;
    w_dbz_nxt   = r_dbz;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Resolved immediately without entering RUN.
            w_quot_nxt = '1;
            w_remd_nxt = bus.dividend;
            w_dbz_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end else begin
            w_rem_nxt   = '0;
            w_work_nxt  = w_a_mag;
            w_dvs_nxt   = w_b_mag;
            w_cnt_nxt   = CW'(WIDTH - 1);
            w_neg_q_nxt = w_a_neg ^ w_b_neg;
            w_neg_r_nxt = w_a_neg;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_rem_nxt  = w_step_rem;
        w_work_nxt = w_step_work;
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_quot_nxt  = w_q_fin;
          w_remd_nxt  = w_r_fin;
          w_dbz_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_work  <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_work  <= w_work_nxt;
      r_dvs   <= w_dvs_nxt;
      r_cnt   <= w_cnt_nxt;
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
      r_quot  <= w_quot_nxt;
      r_remd  <= w_remd_nxt;
      r_done  <= w_done_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule
